// File: rtl/wasm_run_monitor.sv
// Run monitor for a WASM core: tracks run state, counts RUN cycles and
// per-channel events with saturation, latches the first error, and applies a watchdog.
module wasm_run_monitor #(
  parameter int CNT_W   = 32,
  parameter int N_EV    = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_clear,
  input  logic                  i_finish,
  input  logic                  i_error,
  input  logic [N_EV-1:0]       i_event,
  output logic [1:0]            o_state,
  output logic                  o_busy,
  output logic [CNT_W-1:0]      o_cycle_cnt,
  output logic [N_EV*CNT_W-1:0] o_event_cnt,
  output logic                  o_err,
  output logic [CNT_W-1:0]      o_err_cycle
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_TMO  = 2'd3
  } state_t;

  localparam bit WD_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WD_LIMIT = WD_EN ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};

  state_t                  state_r;
  state_t                  next_s;
  logic                    busy_r;
  logic [CNT_W-1:0]        cycle_r;
  logic [N_EV*CNT_W-1:0]   event_cnt_r;
  logic                    err_r;
  logic [CNT_W-1:0]        err_cycle_r;
  logic                    start_run_s;
  logic                    count_s;
  logic                    step_s;
  logic                    wd_hit_s;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Next-state decode; clear has priority over start in every state.
  always_comb begin
    next_s      = state_r;
    start_run_s = 1'b0;
    count_s     = 1'b0;
    step_s      = 1'b0;
    wd_hit_s    = WD_EN && (cycle_r == WD_LIMIT);
    case (state_r)
      ST_RUN: begin
        if (i_clear) begin
          next_s = ST_IDLE;
        end else begin
          count_s = 1'b1;
          if (i_finish) begin
            next_s = ST_DONE;
          end else begin
            step_s = 1'b1;
            if (wd_hit_s) begin
              next_s = ST_TMO;
            end else begin
              next_s = ST_RUN;
            end
          end
        end
      end
      ST_IDLE, ST_DONE, ST_TMO: begin
        if (i_clear) begin
          next_s = ST_IDLE;
        end else if (i_start) begin
          next_s      = ST_RUN;
          start_run_s = 1'b1;
        end else begin
          next_s = state_r;
        end
      end
      default: begin
        next_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and error capture.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      cycle_r     <= {CNT_W{1'b0}};
      event_cnt_r <= {(N_EV*CNT_W){1'b0}};
      err_r       <= 1'b0;
      err_cycle_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= next_s;
      busy_r  <= (next_s == ST_RUN);
      if (start_run_s) begin
        cycle_r     <= {CNT_W{1'b0}};
        event_cnt_r <= {(N_EV*CNT_W){1'b0}};
        err_r       <= 1'b0;
        err_cycle_r <= {CNT_W{1'b0}};
      end else if (count_s) begin
        if (step_s) begin
          cycle_r <= sat_inc(cycle_r);
        end
        for (int k = 0; k < N_EV; k++) begin
          if (i_event[k]) begin
            event_cnt_r[k*CNT_W +: CNT_W] <= sat_inc(event_cnt_r[k*CNT_W +: CNT_W]);
          end
        end
        // Only the first error of a run is recorded, at the pre-increment count.
        if (i_error && !err_r) begin
          err_r       <= 1'b1;
          err_cycle_r <= cycle_r;
        end
      end
    end
  end

  assign o_state     = state_r;
  assign o_busy      = busy_r;
  assign o_cycle_cnt = cycle_r;
  assign o_event_cnt = event_cnt_r;
  assign o_err       = err_r;
  assign o_err_cycle = err_cycle_r;

endmodule
